fifo_push_arbiter: RTL

- Round-robin write arbiter that shares one fifo_flops instance among N_REQ producers.
- Grants one producer at a time for a bounded burst.
- Drives the FIFO push/Din pins and respects the FIFO full flag.
- Sits between producer blocks and the FIFO write port; the FIFO pop side is untouched.

---
 rtl/fifo_push_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/fifo_push_arbiter.sv
// Round-robin write arbiter: grants one producer at a time a bounded burst into a shared fifo_flops write port.
// Optional per-requester accepted-word counters are enabled with `define FIFO_ARB_STATS_EN.
module fifo_push_arbiter #(
    parameter int DATA_W    = 32,
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   din,
    output logic [N_REQ-1:0]          ack,
    output logic [N_REQ-1:0]          grant,
    output logic                      busy,
    input  logic                      fifo_full,
    output logic                      fifo_push,
    output logic [DATA_W-1:0]         fifo_din
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [N_REQ*16-1:0]       push_count
`endif
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  owner;
    logic [IDX_W-1:0]  rr_ptr;
    logic [CNT_W-1:0]  burst_cnt;

    logic [IDX_W-1:0]  pick;
    logic              found;
    logic              owner_req;
    logic              burst_done;
    logic [IDX_W-1:0]  next_ptr;

    // Cyclic search starting at rr_ptr; the first hit wins.
    always_comb begin
        int unsigned      idx;
        logic [IDX_W-1:0] cand;
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        cand  = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            cand = IDX_W'(idx);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign busy      = (state == BURST);
    assign owner_req = req[owner];
    assign fifo_push = busy & owner_req & ~fifo_full;
    assign fifo_din  = busy ? din[owner*DATA_W +: DATA_W] : '0;
    assign next_ptr  = (32'(owner) == N_REQ - 1) ? '0 : owner + 1'b1;
    assign burst_done = ~owner_req | (fifo_push & (burst_cnt == LAST_BEAT));

    always_comb begin
        ack        = '0;
        ack[owner] = fifo_push;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            grant     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        owner     <= pick;
                        grant     <= N_REQ'(1) << pick;
                        burst_cnt <= '0;
                        state     <= BURST;
                    end
                end
                BURST: begin
                    if (fifo_push) burst_cnt <= burst_cnt + 1'b1;
                    if (burst_done) begin
                        rr_ptr <= next_ptr;
                        grant  <= '0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

`ifdef FIFO_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            push_count <= '0;
        end else begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (ack[i] && push_count[i*16 +: 16] != 16'hFFFF)
                    push_count[i*16 +: 16] <= push_count[i*16 +: 16] + 16'd1;
            end
        end
    end
`endif

endmodule
